ex_lane_stage: RTL and testbench
================================

// Module: ex_lane_stage
// PURPOSE
//  N-lane successor of the dual-issue EX front end. Holds the ID->EX pipeline register and gates each
//  lane bus by its valid bit; the per-lane sub_ex units consume these buses. Serialises the single data
//  SRAM port across lanes: a multi-cycle sequencer issues memory requests one per cycle and stalls EX.
// PARAMETERS
//  LANES    2    number of issue lanes (1..4)
//  LANE_W   251  per-lane instruction bus width (INST_BUS_WD)
//  STALL_W  6    stall bus width (StallBus)
// PORTS
//  clk              in   1                    clock
//  rst              in   1                    asynchronous, active-high reset
//  flush            in   1                    pipeline flush
//  stall            in   STALL_W              stall bus; bit 2 = this register, bit 3 = EX/MEM
//  id_to_ex_bus     in   1+LANES*LANE_W+LANES {switch, lane[LANES-1..0], valid[LANES-1:0]}
//  lane_bus         out  LANES*LANE_W         registered lane buses; lane i at [i*LANE_W +: LANE_W]
//  lane_valid       out  LANES                registered valid bits
//  switch_o         out  1                    registered slot-switch bit
//  lane_mem_req     in   LANES                per-lane SRAM request (from sub_ex)
//  lane_mem_wen     in   LANES*4              per-lane byte write enables
//  lane_mem_addr    in   LANES*32             per-lane addresses
//  lane_mem_wdata   in   LANES*32             per-lane write data
//  data_sram_en     out  1                    SRAM enable
//  data_sram_wen    out  4                    SRAM byte write enable
//  data_sram_addr   out  32                   SRAM address
//  data_sram_wdata  out  32                   SRAM write data
//  mem_grant_q      out  LANES                one-hot lane granted the previous cycle (load steering in MEM)
//  mem_served       out  LANES                lanes already issued during the current sequence
//  stallreq_for_ex  out  1                    EX stall request to ctrl
// BEHAVIOUR
//  - Register priority: rst -> 0; flush -> 0; stall[2]=Stop & stall[3]=NoStop -> 0 (bubble);
//    stall[2]=NoStop -> load id_to_ex_bus; otherwise hold.
//  - lane_bus field i = valid[i] ? field : 0. Comb from the register; zero after reset.
//  - pend = lane_mem_req & lane_valid & ~served. grant = lowest set bit of pend. SRAM outputs mux the
//    granted lane's signals (comb); no grant -> en=0, wen=0, addr=0, wdata=0.
//  - FSM IDLE: popcount(pend)<=1 -> pass through, stallreq=0. popcount>=2 -> grant lowest,
//    stallreq=1, served|=grant, go SEQ.
//  - FSM SEQ: grant lowest pending, served|=grant; stallreq=1 while >=2 pending this cycle.
//    On the last grant, stallreq=0, served clears, go IDLE.
//  - ctrl holds stall[2]=stall[3]=Stop while stallreq=1, so the register holds through the sequence.
//  - flush (any state): data_sram_en/wen forced 0 the same cycle; next edge -> IDLE, served=0, mem_grant_q=0.
//  - mem_grant_q <= grant every cycle, or 0 on flush/rst.
//  - Async rst: register, served, mem_grant_q cleared; FSM=IDLE; all outputs 0.
//  - LANES=1: sequencer never leaves IDLE; stallreq_for_ex constant 0.
// CONFIGURATION
//  EX_MEM_PERF_CNT_EN defined: adds out port perf_mem_stall_cnt[31:0]. The counter increments on every
//    cycle with stallreq_for_ex=1, wraps at 2^32, and is cleared only by rst.
//  EX_MEM_PERF_CNT_EN undefined: the port and counter are absent; all other behaviour is identical.
// STRUCTURE
//  defines.vh: StallBus, Stop/NoStop, INST_BUS_WD, ID_TO_EX_WD derived from LANES/LANE_W,
//    FSM state encodings (EXSEQ_IDLE, EXSEQ_SEQ).
//  Sub-module ex_mem_seq: owns the FSM, served mask, priority grant, SRAM mux and mem_grant_q.
//    The top level holds the pipeline register and lane gating.
// TESTING
//  1 rst mid-sequence (SEQ, served=01) -> all outputs 0 immediately; IDLE after release.
//  2 LANES=2, load valid=11, stall=0, lane1 mem only -> lane1 addr on SRAM same cycle, stallreq=0.
//  3 Both lanes store (0x100, 0x104) -> cycle0: addr 0x100, stallreq=1; cycle1: addr 0x104,
//    stallreq=0; mem_grant_q=01 then 10.
//  4 LANES=4, lanes 0,2,3 request -> grants 0,2,3 on consecutive cycles; stallreq 1,1,0.
//  5 flush during cycle0 of case 3 -> en=0 that cycle; next cycle register=0, IDLE, served=0.
//  6 stall[2]=Stop, stall[3]=NoStop -> register zeroed, lane_valid=00 next cycle;
//    with EX_MEM_PERF_CNT_EN, case 3 increments the counter by exactly 1.

Source files
------------

// File: rtl/ex_lane_stage_pkg.sv
// rtl/ex_lane_stage_pkg.sv - shared constants, stall encodings and sequencer state for ex_lane_stage
package ex_lane_stage_pkg;

  localparam int   STALL_BUS_W     = 6;
  localparam int   INST_BUS_WD     = 251;
  localparam logic STOP            = 1'b1;
  localparam logic NO_STOP         = 1'b0;
  localparam int   STALL_REG_BIT   = 2;
  localparam int   STALL_EXMEM_BIT = 3;

  typedef enum logic {
    EXSEQ_IDLE = 1'b0,
    EXSEQ_SEQ  = 1'b1
  } exseq_state_e;

  typedef struct packed {
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
  } sram_req_t;

  // {switch, lane buses, valid bits}
  function automatic int id_to_ex_wd(input int lanes, input int lane_w);
    return 1 + lanes * lane_w + lanes;
  endfunction

endpackage

// File: rtl/ex_mem_seq.sv
// rtl/ex_mem_seq.sv - serialises per-lane data SRAM requests onto the single SRAM port
// Lowest pending lane wins; a served mask carries the multi-cycle sequence.
module ex_mem_seq
  import ex_lane_stage_pkg::*;
#(
  parameter int LANES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic [LANES-1:0]     lane_valid,
  input  logic [LANES-1:0]     lane_mem_req,
  input  logic [LANES*4-1:0]   lane_mem_wen,
  input  logic [LANES*32-1:0]  lane_mem_addr,
  input  logic [LANES*32-1:0]  lane_mem_wdata,
  output logic                 data_sram_en,
  output logic [3:0]           data_sram_wen,
  output logic [31:0]          data_sram_addr,
  output logic [31:0]          data_sram_wdata,
  output logic [LANES-1:0]     mem_grant_q,
  output logic [LANES-1:0]     mem_served,
  output logic                 stallreq
);

  exseq_state_e     state_q, state_d;
  logic [LANES-1:0] served_q, served_d;
  logic [LANES-1:0] grant_q, grant_d;
  logic [LANES-1:0] pend, grant;
  logic [2:0]       pend_cnt;
  sram_req_t        sram;

  always_comb begin
    pend     = lane_mem_req & lane_valid & ~served_q;
    grant    = pend & (~pend + LANES'(1));
    pend_cnt = 3'($countones(pend));

    sram = '0;
    for (int i = 0; i < LANES; i++) begin
      if (grant[i]) begin
        sram.en    = 1'b1;
        sram.wen   = lane_mem_wen[i*4 +: 4];
        sram.addr  = lane_mem_addr[i*32 +: 32];
        sram.wdata = lane_mem_wdata[i*32 +: 32];
      end
    end
    // a flushed access must not reach the SRAM, even mid-sequence
    if (flush) begin
      sram.en  = 1'b0;
      sram.wen = '0;
    end
  end

  always_comb begin
    state_d  = state_q;
    served_d = served_q;
    stallreq = 1'b0;
    case (state_q)
      EXSEQ_IDLE: begin
        if (LANES > 1 && pend_cnt >= 3'd2) begin
          stallreq = 1'b1;
          served_d = served_q | grant;
          state_d  = EXSEQ_SEQ;
        end
      end
      EXSEQ_SEQ: begin
        if (pend_cnt >= 3'd2) begin
          stallreq = 1'b1;
          served_d = served_q | grant;
        end else begin
          served_d = '0;
          state_d  = EXSEQ_IDLE;
        end
      end
    endcase
    if (flush) begin
      served_d = '0;
      state_d  = EXSEQ_IDLE;
    end
    grant_d = flush ? '0 : grant;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= EXSEQ_IDLE;
      served_q <= '0;
      grant_q  <= '0;
    end else begin
      state_q  <= state_d;
      served_q <= served_d;
      grant_q  <= grant_d;
    end
  end

  assign data_sram_en    = sram.en;
  assign data_sram_wen   = sram.wen;
  assign data_sram_addr  = sram.addr;
  assign data_sram_wdata = sram.wdata;
  assign mem_grant_q     = grant_q;
  assign mem_served      = served_q;

endmodule

// File: rtl/ex_lane_stage.sv
// rtl/ex_lane_stage.sv - N-lane ID->EX register with valid gating and shared data SRAM sequencer
// EX_MEM_PERF_CNT_EN adds perf_mem_stall_cnt, a count of EX stall cycles caused by the sequencer.
module ex_lane_stage
  import ex_lane_stage_pkg::*;
#(
  parameter int LANES   = 2,
  parameter int LANE_W  = INST_BUS_WD,
  parameter int STALL_W = STALL_BUS_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic [STALL_W-1:0]          stall,
  input  logic [LANES*LANE_W+LANES:0] id_to_ex_bus,
  output logic [LANES*LANE_W-1:0]     lane_bus,
  output logic [LANES-1:0]            lane_valid,
  output logic                        switch_o,
  input  logic [LANES-1:0]            lane_mem_req,
  input  logic [LANES*4-1:0]          lane_mem_wen,
  input  logic [LANES*32-1:0]         lane_mem_addr,
  input  logic [LANES*32-1:0]         lane_mem_wdata,
  output logic                        data_sram_en,
  output logic [3:0]                  data_sram_wen,
  output logic [31:0]                 data_sram_addr,
  output logic [31:0]                 data_sram_wdata,
  output logic [LANES-1:0]            mem_grant_q,
  output logic [LANES-1:0]            mem_served,
  output logic                        stallreq_for_ex
`ifdef EX_MEM_PERF_CNT_EN
  ,
  output logic [31:0]                 perf_mem_stall_cnt
`endif
);

  localparam int ID_W = id_to_ex_wd(LANES, LANE_W);

  logic [ID_W-1:0] id_q, id_d;
  logic            stall_unused;

  assign stall_unused = ^stall;

  // a stalled ID feeding a running MEM must inject a bubble, not repeat the instruction
  always_comb begin
    id_d = id_q;
    if (flush) begin
      id_d = '0;
    end else if (stall[STALL_REG_BIT] == STOP && stall[STALL_EXMEM_BIT] == NO_STOP) begin
      id_d = '0;
    end else if (stall[STALL_REG_BIT] == NO_STOP) begin
      id_d = id_to_ex_bus;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) id_q <= '0;
    else     id_q <= id_d;
  end

  assign lane_valid = id_q[LANES-1:0];
  assign switch_o   = id_q[ID_W-1];

  always_comb begin
    lane_bus = '0;
    for (int i = 0; i < LANES; i++) begin
      if (lane_valid[i]) lane_bus[i*LANE_W +: LANE_W] = id_q[LANES + i*LANE_W +: LANE_W];
    end
  end

  ex_mem_seq #(
    .LANES(LANES)
  ) u_mem_seq (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .lane_valid     (lane_valid),
    .lane_mem_req   (lane_mem_req),
    .lane_mem_wen   (lane_mem_wen),
    .lane_mem_addr  (lane_mem_addr),
    .lane_mem_wdata (lane_mem_wdata),
    .data_sram_en   (data_sram_en),
    .data_sram_wen  (data_sram_wen),
    .data_sram_addr (data_sram_addr),
    .data_sram_wdata(data_sram_wdata),
    .mem_grant_q    (mem_grant_q),
    .mem_served     (mem_served),
    .stallreq       (stallreq_for_ex)
  );

`ifdef EX_MEM_PERF_CNT_EN
  logic [31:0] perf_cnt_q, perf_cnt_d;

  always_comb perf_cnt_d = perf_cnt_q + {31'd0, stallreq_for_ex};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) perf_cnt_q <= '0;
    else     perf_cnt_q <= perf_cnt_d;
  end

  assign perf_mem_stall_cnt = perf_cnt_q;
`endif

endmodule

// File: tb/tb_ex_lane_stage.sv
// tb/tb_ex_lane_stage.sv - directed scoreboard bench for ex_lane_stage (2-lane and 4-lane instances)
module tb_ex_lane_stage;

  localparam int W2 = 251;
  localparam int W4 = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, flush;

  // 2-lane instance
  logic [5:0]        stall_drv2, stall2;
  logic [2*W2+2:0]   id2;
  logic [2*W2-1:0]   lane_bus2;
  logic [1:0]        lane_valid2, req2, grant_q2, served2;
  logic              switch2, en2, stallreq2;
  logic [7:0]        wen_in2;
  logic [63:0]       addr_in2, wdata_in2;
  logic [3:0]        wen2;
  logic [31:0]       addr2, wdata2;

  // 4-lane instance
  logic [5:0]        stall_drv4, stall4;
  logic [4*W4+4:0]   id4;
  logic [4*W4-1:0]   lane_bus4;
  logic [3:0]        lane_valid4, req4, grant_q4, served4;
  logic              switch4, en4, stallreq4;
  logic [15:0]       wen_in4;
  logic [127:0]      addr_in4, wdata_in4;
  logic [3:0]        wen4;
  logic [31:0]       addr4, wdata4;

`ifdef EX_MEM_PERF_CNT_EN
  logic [31:0] perf2, perf4, perf_start;
`endif

  // ctrl model: hold both ID/EX and EX/MEM while the sequencer asks for a stall
  assign stall2 = stallreq2 ? 6'b001111 : stall_drv2;
  assign stall4 = stallreq4 ? 6'b001111 : stall_drv4;

  ex_lane_stage #(.LANES(2), .LANE_W(W2), .STALL_W(6)) dut2 (
    .clk(clk), .rst(rst), .flush(flush), .stall(stall2), .id_to_ex_bus(id2),
    .lane_bus(lane_bus2), .lane_valid(lane_valid2), .switch_o(switch2),
    .lane_mem_req(req2), .lane_mem_wen(wen_in2), .lane_mem_addr(addr_in2), .lane_mem_wdata(wdata_in2),
    .data_sram_en(en2), .data_sram_wen(wen2), .data_sram_addr(addr2), .data_sram_wdata(wdata2),
    .mem_grant_q(grant_q2), .mem_served(served2), .stallreq_for_ex(stallreq2)
`ifdef EX_MEM_PERF_CNT_EN
    , .perf_mem_stall_cnt(perf2)
`endif
  );

  ex_lane_stage #(.LANES(4), .LANE_W(W4), .STALL_W(6)) dut4 (
    .clk(clk), .rst(rst), .flush(flush), .stall(stall4), .id_to_ex_bus(id4),
    .lane_bus(lane_bus4), .lane_valid(lane_valid4), .switch_o(switch4),
    .lane_mem_req(req4), .lane_mem_wen(wen_in4), .lane_mem_addr(addr_in4), .lane_mem_wdata(wdata_in4),
    .data_sram_en(en4), .data_sram_wen(wen4), .data_sram_addr(addr4), .data_sram_wdata(wdata4),
    .mem_grant_q(grant_q4), .mem_served(served4), .stallreq_for_ex(stallreq4)
`ifdef EX_MEM_PERF_CNT_EN
    , .perf_mem_stall_cnt(perf4)
`endif
  );

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stallreq;
  } exp_t;

  exp_t sb_q[$];

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_expect(input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic sr);
    exp_t e;
    e.wen = wen; e.addr = addr; e.wdata = wdata; e.stallreq = sr;
    sb_q.push_back(e);
  endtask

  task automatic sb_check(input string tag, input logic en, input logic [3:0] wen, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic sr);
    exp_t e;
    chk({tag, "_en"}, en, sb_q.size() > 0);
    if (en && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk({tag, "_wen"}, wen, e.wen);
      chk({tag, "_addr"}, addr, e.addr);
      chk({tag, "_wdata"}, wdata, e.wdata);
      chk({tag, "_stallreq"}, sr, e.stallreq);
    end
  endtask

  logic [W2-1:0] pa, pb, pc;

  initial begin
    pa = 251'h1_dead_beef_0123;
    pb = 251'h7_cafe_f00d_4567;
    pc = 251'h3_0bad_c0de_89ab;
    rst = 1'b1; flush = 1'b0;
    stall_drv2 = '0; stall_drv4 = '0;
    id2 = '0; id4 = '0;
    req2 = '0; wen_in2 = '0; addr_in2 = '0; wdata_in2 = '0;
    req4 = '0; wen_in4 = '0; addr_in4 = '0; wdata_in4 = '0;

    // reset state
    @(negedge clk); #1;
    chk("rst_valid", lane_valid2, 2'b00);
    chk("rst_bus_nz", |lane_bus2, 1'b0);
    chk("rst_switch", switch2, 1'b0);
    chk("rst_en", en2, 1'b0);
    chk("rst_stallreq", stallreq2, 1'b0);
    chk("rst_grant_q", grant_q2, 2'b00);
`ifdef EX_MEM_PERF_CNT_EN
    chk("rst_perf", perf2, 32'd0);
`endif

    // single lane-1 access passes straight through
    @(negedge clk);
    rst = 1'b0;
    id2 = {1'b1, pb, pa, 2'b11};
    @(negedge clk);
    req2 = 2'b10; wen_in2 = 8'h00; addr_in2 = {32'h200, 32'h0}; wdata_in2 = {32'h1111_2222, 32'h0};
    sb_expect(4'h0, 32'h200, 32'h1111_2222, 1'b0);
    #1;
    chk("ld_valid", lane_valid2, 2'b11);
    chk("ld_switch", switch2, 1'b1);
    chk("ld_lane0", lane_bus2[W2-1:0], pa);
    chk("ld_lane1", lane_bus2[2*W2-1:W2], pb);
    sb_check("single", en2, wen2, addr2, wdata2, stallreq2);
    @(negedge clk);
    req2 = 2'b00; #1;
    chk("single_grant_q", grant_q2, 2'b10);
    chk("single_served", served2, 2'b00);

    // valid gating: lane 1 invalid reads as zero
    id2 = {1'b0, pb, pc, 2'b01};
    @(negedge clk); #1;
    chk("gate_valid", lane_valid2, 2'b01);
    chk("gate_lane0", lane_bus2[W2-1:0], pc);
    chk("gate_lane1", lane_bus2[2*W2-1:W2], '0);

    // two stores serialised over two cycles, register held throughout
    id2 = {1'b0, pb, pa, 2'b11};
    @(negedge clk);
    id2 = '0;
    req2 = 2'b11; wen_in2 = 8'hff; addr_in2 = {32'h104, 32'h100}; wdata_in2 = {32'hbbbb_0001, 32'haaaa_0000};
`ifdef EX_MEM_PERF_CNT_EN
    perf_start = perf2;
`endif
    sb_expect(4'hf, 32'h100, 32'haaaa_0000, 1'b1);
    #1;
    sb_check("pair_c0", en2, wen2, addr2, wdata2, stallreq2);
    chk("pair_c0_served", served2, 2'b00);
    @(negedge clk);
    sb_expect(4'hf, 32'h104, 32'hbbbb_0001, 1'b0);
    #1;
    sb_check("pair_c1", en2, wen2, addr2, wdata2, stallreq2);
    chk("pair_c1_grant_q", grant_q2, 2'b01);
    chk("pair_c1_served", served2, 2'b01);
    chk("pair_c1_hold", lane_valid2, 2'b11);
    @(negedge clk);
    req2 = 2'b00; #1;
    chk("pair_c2_grant_q", grant_q2, 2'b10);
    chk("pair_c2_served", served2, 2'b00);
    chk("pair_c2_en", en2, 1'b0);
    chk("pair_c2_valid", lane_valid2, 2'b00);
`ifdef EX_MEM_PERF_CNT_EN
    chk("pair_perf_delta", perf2 - perf_start, 32'd1);
`endif

    // asynchronous reset in the middle of a sequence
    id2 = {1'b1, pb, pa, 2'b11};
    @(negedge clk);
    req2 = 2'b11;
    sb_expect(4'hf, 32'h100, 32'haaaa_0000, 1'b1);
    #1;
    sb_check("rstseq_c0", en2, wen2, addr2, wdata2, stallreq2);
    @(negedge clk); #1;
    chk("rstseq_served", served2, 2'b01);
    rst = 1'b1; #1;
    chk("rstseq_valid", lane_valid2, 2'b00);
    chk("rstseq_bus_nz", |lane_bus2, 1'b0);
    chk("rstseq_switch", switch2, 1'b0);
    chk("rstseq_en", en2, 1'b0);
    chk("rstseq_addr", addr2, 32'h0);
    chk("rstseq_wdata", wdata2, 32'h0);
    chk("rstseq_wen", wen2, 4'h0);
    chk("rstseq_stallreq", stallreq2, 1'b0);
    chk("rstseq_grant_q", grant_q2, 2'b00);
    chk("rstseq_served0", served2, 2'b00);
    @(negedge clk);
    rst = 1'b0; req2 = 2'b00;
    @(negedge clk);
    req2 = 2'b01; addr_in2 = {32'h104, 32'h180};
    sb_expect(4'hf, 32'h180, 32'haaaa_0000, 1'b0);
    #1;
    sb_check("post_rst", en2, wen2, addr2, wdata2, stallreq2);
    chk("post_rst_served", served2, 2'b00);

    // flush during the first cycle of a two-lane sequence
    @(negedge clk);
    req2 = 2'b11; addr_in2 = {32'h104, 32'h100}; flush = 1'b1; #1;
    chk("flush_en", en2, 1'b0);
    chk("flush_wen", wen2, 4'h0);
    @(negedge clk);
    flush = 1'b0; #1;
    chk("flush_valid", lane_valid2, 2'b00);
    chk("flush_served", served2, 2'b00);
    chk("flush_grant_q", grant_q2, 2'b00);
    chk("flush_stallreq", stallreq2, 1'b0);
    chk("flush_en_after", en2, 1'b0);

    // hold versus bubble
    @(negedge clk);
    req2 = 2'b00; #1;
    chk("reload_valid", lane_valid2, 2'b11);
    stall_drv2 = 6'b001100; id2 = {1'b0, pc, pc, 2'b01};
    @(negedge clk); #1;
    chk("hold_valid", lane_valid2, 2'b11);
    chk("hold_switch", switch2, 1'b1);
    stall_drv2 = 6'b000100;
    @(negedge clk); #1;
    chk("bubble_valid", lane_valid2, 2'b00);
    chk("bubble_switch", switch2, 1'b0);
    chk("bubble_bus_nz", |lane_bus2, 1'b0);
    stall_drv2 = 6'b000000;

    // 4 lanes: lanes 0, 2, 3 request
    id4 = {1'b0, 16'hc003, 16'hc002, 16'hc001, 16'hc000, 4'b1111};
    @(negedge clk);
    req4 = 4'b1101;
    wen_in4 = 16'h8421;
    addr_in4 = {32'h30c, 32'h308, 32'h304, 32'h300};
    wdata_in4 = {32'hd3, 32'hd2, 32'hd1, 32'hd0};
    sb_expect(4'h1, 32'h300, 32'hd0, 1'b1);
    #1;
    chk("l4_lane2", lane_bus4[2*W4 +: W4], 16'hc002);
    sb_check("l4_c0", en4, wen4, addr4, wdata4, stallreq4);
    chk("l4_c0_served", served4, 4'b0000);
    @(negedge clk);
    sb_expect(4'h4, 32'h308, 32'hd2, 1'b1);
    #1;
    sb_check("l4_c1", en4, wen4, addr4, wdata4, stallreq4);
    chk("l4_c1_grant_q", grant_q4, 4'b0001);
    chk("l4_c1_served", served4, 4'b0001);
    @(negedge clk);
    sb_expect(4'h8, 32'h30c, 32'hd3, 1'b0);
    #1;
    sb_check("l4_c2", en4, wen4, addr4, wdata4, stallreq4);
    chk("l4_c2_grant_q", grant_q4, 4'b0100);
    chk("l4_c2_served", served4, 4'b0101);
    @(negedge clk);
    req4 = 4'b0000; #1;
    chk("l4_c3_grant_q", grant_q4, 4'b1000);
    chk("l4_c3_served", served4, 4'b0000);
    chk("l4_c3_stallreq", stallreq4, 1'b0);
    chk("l4_c3_en", en4, 1'b0);

    chk("sb_drained", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
